// File: rtl/m_rep_download_pkg.sv
// Shared definitions for the memory-reply download stage.
// Flit control codes are common with the upload stage.
package m_rep_download_pkg;

   localparam int unsigned DEF_FLIT_W    = 16;
   localparam int unsigned DEF_MAX_FLITS = 11;
   localparam int unsigned DEF_MSG_W     = DEF_FLIT_W * DEF_MAX_FLITS;

   localparam logic [1:0] CTRL_NONE = 2'b00;
   localparam logic [1:0] CTRL_HEAD = 2'b01;
   localparam logic [1:0] CTRL_BODY = 2'b10;
   localparam logic [1:0] CTRL_TAIL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ASSEMBLE = 2'b01,
      ST_DONE     = 2'b10
   } dl_state_e;

endpackage

// File: rtl/m_rep_download.sv
// Memory-reply download: reassembles MSB-first reply flits into one message
// and offers it to the consumer with a valid/ack handshake.
// Optional macro M_REP_DOWNLOAD_B2B_EN: accept a new head in the ack cycle.
module m_rep_download
   import m_rep_download_pkg::*;
#(
   parameter int unsigned FLIT_W    = DEF_FLIT_W,
   parameter int unsigned MAX_FLITS = DEF_MAX_FLITS,
   parameter int unsigned MSG_W     = DEF_MSG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] flit_in,
   input  logic              v_flit_in,
   input  logic [1:0]        ctrl_in,
   output logic              flit_rdy,
   output logic [MSG_W-1:0]  m_flits_out,
   output logic              v_m_flits_out,
   input  logic              m_flits_ack,
   output logic [3:0]        flit_cnt,
   output logic              proto_err,
   output logic [1:0]        m_rep_download_state
);

   localparam logic [3:0] MAX_CNT  = 4'(MAX_FLITS);
   localparam logic [3:0] TOP_SLOT = 4'(MAX_FLITS - 1);

   // Packed slots: slot k lives at index MAX_FLITS-1-k, i.e. slot 0 is the MSBs.
   logic [MAX_FLITS-1:0][FLIT_W-1:0] msg_q, msg_d;
   dl_state_e                        state_q, state_d;
   logic [3:0]                       cnt_q, cnt_d;
   logic                             err_q, err_d;
   logic                             accept;

   assign accept = v_flit_in && flit_rdy;

   // State and datapath registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         msg_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state, slot writes and protocol-error detection.
   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (ctrl_in == CTRL_HEAD) begin
                  msg_d           = '0;
                  msg_d[TOP_SLOT] = flit_in;
                  cnt_d           = 4'd1;
                  state_d         = ST_ASSEMBLE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ASSEMBLE: begin
            if (accept) begin
               if (ctrl_in == CTRL_HEAD) begin
                  msg_d           = '0;
                  msg_d[TOP_SLOT] = flit_in;
                  cnt_d           = 4'd1;
                  err_d           = 1'b1;
               end else if (cnt_q >= MAX_CNT) begin
                  // Overflow takes priority over the none-code check.
                  msg_d   = '0;
                  cnt_d   = '0;
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else if (ctrl_in == CTRL_NONE) begin
                  err_d = 1'b1;
               end else begin
                  msg_d[TOP_SLOT - cnt_q] = flit_in;
                  cnt_d                   = cnt_q + 4'd1;
                  if (ctrl_in == CTRL_TAIL) begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            if (m_flits_ack) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
`ifdef M_REP_DOWNLOAD_B2B_EN
               if (accept) begin
                  if (ctrl_in == CTRL_HEAD) begin
                     msg_d           = '0;
                     msg_d[TOP_SLOT] = flit_in;
                     cnt_d           = 4'd1;
                     state_d         = ST_ASSEMBLE;
                  end else begin
                     err_d = 1'b1;
                  end
               end
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from registered state plus the ready path.
   always_comb begin
`ifdef M_REP_DOWNLOAD_B2B_EN
      flit_rdy = (state_q != ST_DONE) || m_flits_ack;
`else
      flit_rdy = (state_q != ST_DONE);
`endif
      v_m_flits_out        = (state_q == ST_DONE);
      m_flits_out          = msg_q;
      flit_cnt             = cnt_q;
      proto_err            = err_q;
      m_rep_download_state = state_q;
   end

endmodule

// File: tb/tb_m_rep_download.sv
// Self-checking bench for m_rep_download: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_m_rep_download;

   localparam logic [1:0] C_NONE = 2'b00;
   localparam logic [1:0] C_HEAD = 2'b01;
   localparam logic [1:0] C_BODY = 2'b10;
   localparam logic [1:0] C_TAIL = 2'b11;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  flit_in;
   logic         v_flit_in;
   logic [1:0]   ctrl_in;
   logic         flit_rdy;
   logic [175:0] m_flits_out;
   logic         v_m_flits_out;
   logic         m_flits_ack;
   logic [3:0]   flit_cnt;
   logic         proto_err;
   logic [1:0]   m_rep_download_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase 0 = waiting for head, 1 = collecting, 2 = message ready
   int          phase;
   logic [15:0] q[$];
   bit          err_exp;

   m_rep_download dut (
      .clk                  (clk),
      .rst                  (rst),
      .flit_in              (flit_in),
      .v_flit_in            (v_flit_in),
      .ctrl_in              (ctrl_in),
      .flit_rdy             (flit_rdy),
      .m_flits_out          (m_flits_out),
      .v_m_flits_out        (v_m_flits_out),
      .m_flits_ack          (m_flits_ack),
      .flit_cnt             (flit_cnt),
      .proto_err            (proto_err),
      .m_rep_download_state (m_rep_download_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [175:0] model_msg();
      logic [175:0] m;
      m = '0;
      foreach (q[i]) m = m | ({160'b0, q[i]} << (16 * (10 - i)));
      return m;
   endfunction

   function automatic bit model_rdy(input bit ack);
`ifdef M_REP_DOWNLOAD_B2B_EN
      return (phase != 2) || ack;
`else
      return (phase != 2);
`endif
   endfunction

   // Compare all DUT outputs against the model (called mid-cycle, inputs applied).
   task automatic check_outputs();
      chk("flit_rdy",  176'(flit_rdy),             176'(model_rdy(m_flits_ack)));
      chk("state",     176'(m_rep_download_state), 176'(phase));
      chk("flit_cnt",  176'(flit_cnt),             176'(phase == 0 ? 0 : q.size()));
      chk("v_msg",     176'(v_m_flits_out),        176'(phase == 2));
      chk("msg",       m_flits_out,                model_msg());
      chk("proto_err", 176'(proto_err),            176'(err_exp));
   endtask

   // Advance the model by one clock edge with the currently driven inputs.
   task automatic model_step();
      bit acc;
      acc     = v_flit_in && model_rdy(m_flits_ack);
      err_exp = 1'b0;
      if (rst) begin
         phase = 0;
         q.delete();
      end else if (phase == 0) begin
         if (acc) begin
            if (ctrl_in == C_HEAD) begin q.delete(); q.push_back(flit_in); phase = 1; end
            else err_exp = 1'b1;
         end
      end else if (phase == 1) begin
         if (acc) begin
            if (ctrl_in == C_HEAD) begin
               q.delete(); q.push_back(flit_in); err_exp = 1'b1;
            end else if (q.size() == 11) begin
               q.delete(); phase = 0; err_exp = 1'b1;
            end else if (ctrl_in == C_NONE) begin
               err_exp = 1'b1;
            end else begin
               q.push_back(flit_in);
               if (ctrl_in == C_TAIL) phase = 2;
            end
         end
      end else begin
         if (m_flits_ack) begin
            phase = 0;
            if (acc) begin
               if (ctrl_in == C_HEAD) begin q.delete(); q.push_back(flit_in); phase = 1; end
               else err_exp = 1'b1;
            end
         end
      end
   endtask

   // One cycle: drive at negedge, check #1 later, clock, update model.
   task automatic cyc(input bit v, input logic [1:0] c, input logic [15:0] f,
                      input bit ack, input bit r);
      v_flit_in   = v;
      ctrl_in     = c;
      flit_in     = f;
      m_flits_ack = ack;
      rst         = r;
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   initial begin
      bit          rv, va, ak;
      logic [1:0]  cc;
      int          x;

      rst = 1'b1; v_flit_in = 1'b0; ctrl_in = C_NONE; flit_in = '0; m_flits_ack = 1'b0;
      phase = 0; err_exp = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // Reset values
      cyc(0, C_NONE, 16'h0, 0, 1);
      chk("rst_state", 176'(m_rep_download_state), 176'(2'b00));
      chk("rst_rdy",   176'(flit_rdy),             176'(1'b1));
      chk("rst_cnt",   176'(flit_cnt),             176'(4'd0));
      chk("rst_v",     176'(v_m_flits_out),        176'(1'b0));
      chk("rst_msg",   m_flits_out,                176'h0);

      // Full 11-flit message
      cyc(1, C_HEAD, 16'hA000, 0, 0);
      for (int i = 1; i <= 9; i++) cyc(1, C_BODY, 16'hA000 + 16'(i), 0, 0);
      cyc(1, C_TAIL, 16'hA00A, 0, 0);
      chk("full_v",   176'(v_m_flits_out), 176'(1'b1));
      chk("full_cnt", 176'(flit_cnt),      176'(4'd11));
      chk("full_msg", m_flits_out,
          176'hA000_A001_A002_A003_A004_A005_A006_A007_A008_A009_A00A);
      cyc(0, C_NONE, 16'h0, 1, 0);
      chk("ack_idle", 176'(m_rep_download_state), 176'(2'b00));

      // Two-flit message held with ack low
      cyc(1, C_HEAD, 16'h1111, 0, 0);
      cyc(1, C_TAIL, 16'h2222, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, C_NONE, 16'h0, 0, 0);
         chk("hold_rdy", 176'(flit_rdy), 176'(1'b0));
      end
      chk("short_msg", m_flits_out, {32'h1111_2222, 144'h0});
      chk("short_cnt", 176'(flit_cnt), 176'(4'd2));
      cyc(0, C_NONE, 16'h0, 1, 0);
      chk("short_idle", 176'(m_rep_download_state), 176'(2'b00));

      // Stray body in idle, then restart on a second head
      cyc(1, C_BODY, 16'h3333, 0, 0);
      chk("stray_err",   176'(proto_err),            176'(1'b1));
      chk("stray_state", 176'(m_rep_download_state), 176'(2'b00));
      cyc(1, C_HEAD, 16'h4444, 0, 0);
      chk("stray_err_clr", 176'(proto_err), 176'(1'b0));
      cyc(1, C_BODY, 16'h5555, 0, 0);
      cyc(1, C_HEAD, 16'h6666, 0, 0);
      chk("restart_err", 176'(proto_err), 176'(1'b1));
      cyc(1, C_TAIL, 16'h7777, 0, 0);
      chk("restart_msg", m_flits_out, {32'h6666_7777, 144'h0});

      // Back-to-back ack with a new head
      cyc(1, C_HEAD, 16'h8888, 1, 0);
`ifdef M_REP_DOWNLOAD_B2B_EN
      chk("b2b_state", 176'(m_rep_download_state), 176'(2'b01));
      chk("b2b_cnt",   176'(flit_cnt),             176'(4'd1));
      cyc(1, C_TAIL, 16'h9999, 0, 0);
      cyc(0, C_NONE, 16'h0, 1, 0);
`else
      chk("b2b_state", 176'(m_rep_download_state), 176'(2'b00));
      chk("b2b_cnt",   176'(flit_cnt),             176'(4'd0));
`endif

      // Overflow
      cyc(1, C_HEAD, 16'hB000, 0, 0);
      for (int i = 1; i <= 10; i++) cyc(1, C_BODY, 16'hB000 + 16'(i), 0, 0);
      chk("ovf_full_cnt", 176'(flit_cnt), 176'(4'd11));
      cyc(1, C_BODY, 16'hBBBB, 0, 0);
      chk("ovf_err",   176'(proto_err),            176'(1'b1));
      chk("ovf_state", 176'(m_rep_download_state), 176'(2'b00));
      chk("ovf_cnt",   176'(flit_cnt),             176'(4'd0));
      chk("ovf_v",     176'(v_m_flits_out),        176'(1'b0));

      // Reset mid-message, then a full message
      cyc(1, C_HEAD, 16'hC000, 0, 0);
      for (int i = 1; i <= 3; i++) cyc(1, C_BODY, 16'hC000 + 16'(i), 0, 0);
      cyc(0, C_NONE, 16'h0, 0, 1);
      chk("mrst_state", 176'(m_rep_download_state), 176'(2'b00));
      chk("mrst_cnt",   176'(flit_cnt),             176'(4'd0));
      chk("mrst_v",     176'(v_m_flits_out),        176'(1'b0));
      cyc(1, C_HEAD, 16'hD000, 0, 0);
      for (int i = 1; i <= 9; i++) cyc(1, C_BODY, 16'hD000 + 16'(i), 0, 0);
      cyc(1, C_TAIL, 16'hD00A, 0, 0);
      chk("mrst_full_msg", m_flits_out,
          176'hD000_D001_D002_D003_D004_D005_D006_D007_D008_D009_D00A);
      cyc(0, C_NONE, 16'h0, 1, 0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rv = ($urandom_range(0, 299) == 0);
         va = ($urandom_range(0, 3) != 0);
         ak = ($urandom_range(0, 2) == 0);
         if (phase == 0) begin
            cc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : C_HEAD;
         end else if (phase == 1) begin
            x = $urandom_range(0, 39);
            cc = (x < 1) ? C_HEAD : (x < 2) ? C_NONE : (x < 7) ? C_TAIL : C_BODY;
         end else begin
            cc = ($urandom_range(0, 1) == 1) ? C_HEAD : C_BODY;
         end
         cyc(va, cc, 16'($urandom), ak, rv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/m_rep_download.md
Name: m_rep_download

Overview:
- Receive side of the memory-reply path: collects 16-bit reply flits arriving from the ring network's reply FIFO and reassembles them into one 176-bit reply message.
- Presents the message to the consuming cache/controller with a valid/ack handshake.
- Mirror of the upload stage. Uses the same flit control encoding and the same MSB-first flit ordering, so an uploaded message reassembles bit-exact.

Parameters:
- FLIT_W, 16, flit width in bits.
- MAX_FLITS, 11, message capacity in flits (MSG_W/FLIT_W).
- MSG_W, 176, reassembled message width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- flit_in  input  FLIT_W  incoming flit.
- v_flit_in  input  1  flit_in/ctrl_in valid.
- ctrl_in  input  2  flit type: 01 head, 10 body, 11 tail, 00 invalid.
- flit_rdy  output  1  block can accept a flit this cycle.
- m_flits_out  output  MSG_W  reassembled message.
- v_m_flits_out  output  1  message valid.
- m_flits_ack  input  1  consumer takes message.
- flit_cnt  output  4  flits stored in current message.
- proto_err  output  1  one-cycle pulse on protocol violation.
- m_rep_download_state  output  2  FSM state.

Behaviour:
- Reset values: m_flits_out=0, v_m_flits_out=0, flit_cnt=0, proto_err=0, state=IDLE(00), flit_rdy=1.
- rst acts mid-message: partial message is discarded and all registers clear on the next edge.
- Accept condition: a flit is accepted iff v_flit_in && flit_rdy.
- flit_rdy = (state != DONE) in the base configuration.
- Slot mapping: slot k occupies bits [MSG_W-1-FLIT_W*k -: FLIT_W], so slot 0 is at [175:160] and slot 10 at [15:0].
- States: IDLE=00, ASSEMBLE=01, DONE=10.
- IDLE, head accepted: message register cleared except slot 0, which is loaded with flit_in. flit_cnt=1. Go to ASSEMBLE.
- IDLE, accepted body/tail/00 flit: dropped, proto_err pulses, stay IDLE.
- ASSEMBLE, body accepted: written to slot flit_cnt, flit_cnt+1.
- ASSEMBLE, tail accepted: written to slot flit_cnt, flit_cnt+1, go to DONE.
- ASSEMBLE, head accepted: restart. Register cleared, slot 0 loaded, flit_cnt=1, proto_err pulses, stay ASSEMBLE.
- ASSEMBLE, 00 flit accepted: ignored, proto_err pulses.
- Overflow: any accepted non-head flit when flit_cnt==MAX_FLITS is dropped; proto_err pulses; go to IDLE with flit_cnt=0 and the message discarded.
- Single-flit message: a head followed by a tail gives flit_cnt=2. There is no head+tail combined code.
- DONE: v_m_flits_out=1 and m_flits_out holds the message. Unwritten slots are zero.
- DONE, m_flits_ack=1: go to IDLE on the next edge, clear flit_cnt and v_m_flits_out. m_flits_out holds its value until the next head.
- Latency: tail accepted on edge N gives v_m_flits_out=1 from cycle N+1. Without the optional feature, at least one cycle separates ack from the next head acceptance.
- m_flits_ack outside DONE is ignored.
- flit_cnt never exceeds MAX_FLITS (4-bit, no wrap).

Optional Feature:
- Macro: M_REP_DOWNLOAD_B2B_EN.
- Defined: flit_rdy = (state != DONE) || m_flits_ack, a combinational path from ack. A head accepted in the ack cycle loads slot 0, sets flit_cnt=1 and goes directly DONE→ASSEMBLE. A non-head flit accepted in that cycle is dropped with proto_err and the FSM goes to IDLE.
- Undefined: flit_rdy is low throughout DONE, giving one bubble cycle.

Decomposition:
- Shared package holds:
  - flit ctrl codes CTRL_HEAD=2'b01, CTRL_BODY=2'b10, CTRL_TAIL=2'b11, CTRL_NONE=2'b00 (also used by the upload stage);
  - state encoding constants;
  - FLIT_W/MSG_W/MAX_FLITS defaults.
- Single module; no sub-module is natural.

Test Plan:
- Head 0xA000, body 0xA001..0xA009, tail 0xA00A, one flit per cycle -> v_m_flits_out one cycle after tail; m_flits_out = 0xA000_A001_..._A00A; flit_cnt=11; proto_err never pulses.
- Head 0x1111, tail 0x2222, hold ack low 5 cycles -> m_flits_out[175:144]=0x1111_2222, rest 0; flit_rdy=0 for all 5 cycles; ack -> IDLE next cycle.
- Body 0x3333 while IDLE -> proto_err 1 cycle, state stays 00. Then head 0x4444, body 0x5555, head 0x6666, tail 0x7777 -> proto_err on the second head; output [175:144]=0x6666_7777.
- Head plus 10 bodies (flit_cnt=11), then a body -> proto_err pulse, state IDLE, flit_cnt=0, v_m_flits_out stays 0.
- rst asserted after head and 3 bodies -> next cycle state=00, flit_cnt=0, v_m_flits_out=0. A following full message assembles correctly.
- With M_REP_DOWNLOAD_B2B_EN: ack and new head 0x8888 in the same cycle -> state 01, flit_cnt=1 next cycle, no bubble. Without the macro, the head offered that cycle is not accepted (flit_rdy=0).
